// File: rtl/bp_tlb_asid.sv
// Fully-associative ASID-tagged TLB with global and superpage entries, tree-PLRU replacement.
// Optional saturating perf counters are enabled with `define BP_TLB_PERF_CNT_EN.
module bp_tlb_asid #(
  parameter int els_p          = 8,
  parameter int vtag_width_p   = 27,
  parameter int ptag_width_p   = 28,
  parameter int asid_width_p   = 9,
  parameter int levels_p       = 3,
  parameter int pg_idx_width_p = 9,
  parameter int entry_width_lp = ptag_width_p + 6,
  parameter int lvl_width_lp   = (levels_p > 1) ? $clog2(levels_p) : 1
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      translation_en_i,
  input  logic [asid_width_p-1:0]   asid_i,
  input  logic                      r_v_i,
  input  logic [vtag_width_p-1:0]   r_vtag_i,
  input  logic                      w_v_i,
  input  logic [vtag_width_p-1:0]   w_vtag_i,
  input  logic [entry_width_lp-1:0] w_entry_i,
  input  logic [lvl_width_lp-1:0]   w_level_i,
  input  logic                      flush_v_i,
  input  logic [1:0]                flush_mode_i,
  input  logic [asid_width_p-1:0]   flush_asid_i,
  input  logic [vtag_width_p-1:0]   flush_vtag_i,
  output logic                      v_o,
  output logic [entry_width_lp-1:0] entry_o,
  output logic                      miss_v_o,
  output logic [vtag_width_p-1:0]   miss_vtag_o
`ifdef BP_TLB_PERF_CNT_EN
  ,
  output logic [31:0]               hit_cnt_o,
  output logic [31:0]               miss_cnt_o,
  output logic [31:0]               flush_cnt_o
`endif
);

  localparam int idx_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int g_bit_lp = 5;

  logic [els_p-1:0]                     valid_q, valid_d;
  logic [els_p-1:0][vtag_width_p-1:0]   vtag_q, vtag_d;
  logic [els_p-1:0][asid_width_p-1:0]   asid_q, asid_d;
  logic [els_p-1:0][lvl_width_lp-1:0]   level_q, level_d;
  logic [els_p-1:0][entry_width_lp-1:0] tlb_q, tlb_d;
  logic [els_p-2:0]                     plru_q, plru_d;
  logic                                 v_q, v_d, miss_v_q, miss_v_d;
  logic [entry_width_lp-1:0]            entry_q, entry_d;
  logic [vtag_width_p-1:0]              miss_vtag_q, miss_vtag_d;

  logic [els_p-1:0] r_match, w_match, f_asid, f_vtag;
  logic [idx_w_lp-1:0] hit_way, fill_hit_way, inv_way, victim, fill_way;
  logic [ptag_width_p-1:0] vtag_ext, pmask, hit_ptag;

  function automatic logic [vtag_width_p-1:0] vmask(input logic [lvl_width_lp-1:0] lvl);
    return {vtag_width_p{1'b1}} << (int'(lvl) * pg_idx_width_p);
  endfunction

  // Tree nodes: children of n are 2n+1 / 2n+2; a 0 bit means the victim lies on the left.
  function automatic logic [els_p-2:0] plru_touch(input logic [els_p-2:0] cur,
                                                 input logic [idx_w_lp-1:0] way);
    logic [els_p-2:0]    nxt;
    logic [idx_w_lp-1:0] n;
    nxt = cur;
    n   = '0;
    for (int d = idx_w_lp-1; d >= 0; d--) begin
      nxt[n] = ~way[d];
      n      = idx_w_lp'(2*n + 1 + int'(way[d]));
    end
    return nxt;
  endfunction

  function automatic logic [idx_w_lp-1:0] plru_victim(input logic [els_p-2:0] cur);
    logic [idx_w_lp-1:0] v;
    logic [idx_w_lp-1:0] n;
    v = '0;
    n = '0;
    for (int d = idx_w_lp-1; d >= 0; d--) begin
      v[d] = cur[n];
      n    = idx_w_lp'(2*n + 1 + int'(cur[n]));
    end
    return v;
  endfunction

  always_comb begin
    for (int i = 0; i < els_p; i++) begin
      r_match[i] = valid_q[i] && (tlb_q[i][g_bit_lp] || asid_q[i] == asid_i)
                   && (((vtag_q[i] ^ r_vtag_i) & vmask(level_q[i])) == '0);
      w_match[i] = valid_q[i] && (tlb_q[i][g_bit_lp] || asid_q[i] == asid_i)
                   && (level_q[i] == w_level_i)
                   && (((vtag_q[i] ^ w_vtag_i) & vmask(w_level_i)) == '0);
      f_asid[i]  = !tlb_q[i][g_bit_lp] && (asid_q[i] == flush_asid_i);
      f_vtag[i]  = (((vtag_q[i] ^ flush_vtag_i) & vmask(level_q[i])) == '0);
    end
  end

  // Descending scan leaves the lowest matching index.
  always_comb begin
    hit_way      = '0;
    fill_hit_way = '0;
    inv_way      = '0;
    for (int i = els_p-1; i >= 0; i--) begin
      if (r_match[i]) hit_way      = idx_w_lp'(i);
      if (w_match[i]) fill_hit_way = idx_w_lp'(i);
      if (!valid_q[i]) inv_way     = idx_w_lp'(i);
    end
  end

  assign victim   = plru_victim(plru_q);
  assign fill_way = (|w_match) ? fill_hit_way : (!(&valid_q)) ? inv_way : victim;

  // Superpage: low ptag bits come from the request VPN.
  assign vtag_ext = ptag_width_p'(r_vtag_i);
  assign pmask    = {ptag_width_p{1'b1}} << (int'(level_q[hit_way]) * pg_idx_width_p);
  assign hit_ptag = (tlb_q[hit_way][entry_width_lp-1:6] & pmask) | (vtag_ext & ~pmask);

  always_comb begin
    valid_d     = valid_q;
    vtag_d      = vtag_q;
    asid_d      = asid_q;
    level_d     = level_q;
    tlb_d       = tlb_q;
    plru_d      = plru_q;
    v_d         = 1'b0;
    miss_v_d    = 1'b0;
    entry_d     = entry_q;
    miss_vtag_d = miss_vtag_q;
    if (flush_v_i) begin
      unique case (flush_mode_i)
        2'd0: begin
          valid_d = '0;
          plru_d  = '0;
        end
        2'd1:    valid_d = valid_q & ~f_asid;
        2'd2:    valid_d = valid_q & ~f_vtag;
        default: valid_d = valid_q & ~(f_asid & f_vtag);
      endcase
    end else if (w_v_i) begin
      if (translation_en_i) begin
        valid_d[fill_way] = 1'b1;
        vtag_d[fill_way]  = w_vtag_i;
        asid_d[fill_way]  = asid_i;
        level_d[fill_way] = w_level_i;
        tlb_d[fill_way]   = w_entry_i;
        plru_d            = plru_touch(plru_q, fill_way);
      end
    end else if (r_v_i) begin
      if (!translation_en_i) begin
        v_d     = 1'b1;
        entry_d = {vtag_ext, 6'b011111};
      end else if (|r_match) begin
        v_d     = 1'b1;
        entry_d = {hit_ptag, tlb_q[hit_way][5:0]};
        plru_d  = plru_touch(plru_q, hit_way);
      end else begin
        miss_v_d    = 1'b1;
        miss_vtag_d = r_vtag_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      valid_q     <= '0;
      vtag_q      <= '0;
      asid_q      <= '0;
      level_q     <= '0;
      tlb_q       <= '0;
      plru_q      <= '0;
      v_q         <= 1'b0;
      miss_v_q    <= 1'b0;
      entry_q     <= '0;
      miss_vtag_q <= '0;
    end else begin
      valid_q     <= valid_d;
      vtag_q      <= vtag_d;
      asid_q      <= asid_d;
      level_q     <= level_d;
      tlb_q       <= tlb_d;
      plru_q      <= plru_d;
      v_q         <= v_d;
      miss_v_q    <= miss_v_d;
      entry_q     <= entry_d;
      miss_vtag_q <= miss_vtag_d;
    end
  end

  assign v_o         = v_q;
  assign miss_v_o    = miss_v_q;
  assign entry_o     = entry_q;
  assign miss_vtag_o = miss_vtag_q;

`ifdef BP_TLB_PERF_CNT_EN
  logic        hit_evt, miss_evt;
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d, flush_cnt_q, flush_cnt_d;

  assign hit_evt  = r_v_i && !w_v_i && !flush_v_i && translation_en_i && (|r_match);
  assign miss_evt = r_v_i && !w_v_i && !flush_v_i && translation_en_i && !(|r_match);

  always_comb begin
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (hit_evt && hit_cnt_q != '1)     hit_cnt_d   = hit_cnt_q + 32'd1;
    if (miss_evt && miss_cnt_q != '1)   miss_cnt_d  = miss_cnt_q + 32'd1;
    if (flush_v_i && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      flush_cnt_q <= '0;
    end else begin
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hit_cnt_o   = hit_cnt_q;
  assign miss_cnt_o  = miss_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  // Counters are not built in this configuration.
`endif

endmodule
